exmem_wb_block: RTL and testbench
=================================

# exmem_wb_block

Back end of the five-stage pipeline: takes the EX-stage result and the ID/EX control bits (`Dmem1ALUOUT`, `DmemREB`, `DmemWEB`, `IDEXrd`, `IDEXregWrite`), runs the data-memory access with a ready handshake, and drives the register-file write port (`regfile_indata`, rd, write enable). It also exposes EX/MEM and MEM/WB forwarding values. It raises `Stall` to hold the front end while the data memory is slow.

## Interface
- `RESET_PC`: none. This block has no parameters; all widths are fixed (32-bit data, 5-bit register index).
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `ALUResult` in 32: EX-stage ALU output; also the memory address for loads and stores.
- `StoreData` in 32: EX-stage rs2 value, written to memory on stores.
- `Dmem1ALUOUT` in 1: 1 = write back memory read data; 0 = write back `ALUResult`.
- `DmemREB` in 1: active-low load request.
- `DmemWEB` in 1: active-low store request.
- `IDEXrd` in 5: destination register.
- `IDEXregWrite` in 1: instruction writes rd.
- `dmem_addr` out 32: memory address.
- `dmem_wdata` out 32: store data.
- `dmem_reb` out 1: active-low read strobe.
- `dmem_web` out 1: active-low write strobe.
- `dmem_rdata` in 32: read data; valid in the cycle `dmem_ready` is high.
- `dmem_ready` in 1: access completes this cycle.
- `Stall` out 1: hold IF/ID/EX; this block ignores its EX inputs while `Stall` is high.
- `EXMEMrd` out 5, `EXMEMregWrite` out 1, `EXMEMvalue` out 32: M-stage forwarding; `EXMEMvalue` is the registered `ALUResult`.
- `regfile_indata` out 32, `WBrd` out 5, `WBregWrite` out 1: register-file write port.

## Operation
- **M register.** Captures `ALUResult`, `StoreData`, `Dmem1ALUOUT`, REB, WEB, rd and regWrite on each edge where `Stall` = 0. It holds its contents while `Stall` = 1.
- **Register-0 writes.** If rd = 0, regWrite is forced to 0 at capture.
- **REB and WEB both low.** The store wins: the load is suppressed and regWrite is forced to 0.
- **FSM states:** M_IDLE, M_ACCESS, M_WAIT.
  - M_IDLE: the M register holds no memory op. `dmem_reb` = `dmem_web` = 1.
  - M_ACCESS: entered on the edge that captures a memory op (also entered directly from M_ACCESS/M_WAIT when a new memory op is captured). Strobes are driven low per the M-register op.
    - `dmem_ready` = 1: the access completes this cycle. Next state is M_ACCESS if a new memory op is captured, else M_IDLE.
    - `dmem_ready` = 0: next state is M_WAIT.
  - M_WAIT: strobes, address and data are held stable. The block stays here until `dmem_ready` = 1, then behaves as completion from M_ACCESS.
- **Stall.** `Stall` = (state ∈ {M_ACCESS, M_WAIT}) & ~`dmem_ready`. It is combinational.
- **WB register.** Loaded on every edge.
  - When the M stage completes (no memory op, or a memory op with `dmem_ready` = 1): data = `Dmem1ALUOUT` ? `dmem_rdata` : M.ALUResult, together with M.rd and M.regWrite.
  - When `Stall` = 1: a bubble is inserted (`WBregWrite` = 0; data and rd are don't-care but held).
- **Output drive.** `regfile_indata`, `WBrd` and `WBregWrite` come directly from the WB register. The regfile writes them at the next edge.
- **Forwarding.** The `EXMEM*` outputs come directly from the M register. `EXMEMregWrite` is 0 while M holds a load (`Dmem1ALUOUT` = 1), because load data is not yet available.

## Timing
- **Reset.** While `RST` is high, every register is 0 and the state is M_IDLE. All outputs read 0, except `dmem_reb` = `dmem_web` = 1 (inactive), effective immediately and asynchronously.
- **Reset mid-access.** The access is abandoned, strobes deassert asynchronously, and no WB write results.
- **Latency with a zero-wait memory.** An input captured at edge n reaches `regfile_indata`/`WBregWrite` after edge n+1, so the register file updates at edge n+2.
- **Wait states.** Each cycle with `dmem_ready` low in M_ACCESS/M_WAIT adds one `Stall` cycle and one WB bubble.
- **Back-to-back memory ops.** Throughput is one per cycle with zero-wait memory; the state stays in M_ACCESS.
- **Stray ready.** `dmem_ready` is ignored in M_IDLE.

## Test plan
- **Reset.** Assert `RST` asynchronously mid-cycle → `regfile_indata` = 0, `WBregWrite` = 0, `Stall` = 0, strobes = 1 without waiting for a `CLK` edge.
- **ALU op.** `ALUResult` = 0x0000_1234, rd = 5, regWrite = 1, REB = WEB = 1 → after the second edge `regfile_indata` = 0x1234, `WBrd` = 5, `WBregWrite` = 1. `EXMEMvalue` = 0x1234 after the first edge.
- **Load with 2 wait states.** `ALUResult` = 0x100, REB = 0, `Dmem1ALUOUT` = 1, rd = 7. `dmem_ready` is low for 2 cycles, then high with `dmem_rdata` = 0xDEAD_BEEF. Required:
  - `dmem_addr` = 0x100 held for 3 cycles.
  - `Stall` = 1 for exactly 2 cycles.
  - 2 WB bubbles, then `regfile_indata` = 0xDEAD_BEEF, `WBrd` = 7.
  - `EXMEMregWrite` = 0 throughout.
- **Store.** WEB = 0, `ALUResult` = 0x40, `StoreData` = 0xA5A5_A5A5, zero-wait → `dmem_web` = 0 for 1 cycle with addr 0x40 and data 0xA5A5_A5A5. `WBregWrite` = 0.
- **Illegal and register-0 cases.**
  - REB = WEB = 0 → only `dmem_web` is asserted and `WBregWrite` = 0.
  - rd = 0 with regWrite = 1 → `WBregWrite` = 0.
- **Reset during M_WAIT.** Assert `RST` while in M_WAIT → strobes go to 1 immediately. After reset is released and a new ALU op is issued, that op completes normally with no write from the abandoned load.

Source files
------------

// File: rtl/exmem_wb_block.sv
// M and WB stages: data-memory access with a ready handshake, then the register-file write port.
// Latency: EX capture at edge n reaches WB after edge n+1. Stall holds EX while the memory is not ready.
module exmem_wb_block (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  input  logic        Dmem1ALUOUT,
  input  logic        DmemREB,
  input  logic        DmemWEB,
  input  logic [4:0]  IDEXrd,
  input  logic        IDEXregWrite,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_reb,
  output logic        dmem_web,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        Stall,
  output logic [4:0]  EXMEMrd,
  output logic        EXMEMregWrite,
  output logic [31:0] EXMEMvalue,
  output logic [31:0] regfile_indata,
  output logic [4:0]  WBrd,
  output logic        WBregWrite
);

  localparam logic [1:0] M_IDLE   = 2'd0;
  localparam logic [1:0] M_ACCESS = 2'd1;
  localparam logic [1:0] M_WAIT   = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;

  logic [31:0] m_alu;
  logic [31:0] m_store;
  logic        m_sel;
  logic        m_reb;
  logic        m_web;
  logic [4:0]  m_rd;
  logic        m_rw;

  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;

  logic        cap_load;
  logic        cap_store;
  logic        cap_mem;
  logic        cap_rw;

  // A store issued together with a load wins; the load and its writeback are dropped.
  assign cap_store = ~DmemWEB;
  assign cap_load  = ~DmemREB & DmemWEB;
  assign cap_mem   = cap_load | cap_store;
  assign cap_rw    = IDEXregWrite & (IDEXrd != 5'd0) & ~(~DmemREB & ~DmemWEB);

  assign Stall = (state != M_IDLE) & ~dmem_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      M_IDLE:           state_nxt = cap_mem ? M_ACCESS : M_IDLE;
      M_ACCESS, M_WAIT: begin
        if (!dmem_ready) state_nxt = M_WAIT;
        else             state_nxt = cap_mem ? M_ACCESS : M_IDLE;
      end
      default:          state_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= M_IDLE;
      m_alu   <= 32'd0;
      m_store <= 32'd0;
      m_sel   <= 1'b0;
      m_reb   <= 1'b0;
      m_web   <= 1'b0;
      m_rd    <= 5'd0;
      m_rw    <= 1'b0;
      wb_data <= 32'd0;
      wb_rd   <= 5'd0;
      wb_we   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!Stall) begin
        m_alu   <= ALUResult;
        m_store <= StoreData;
        m_sel   <= Dmem1ALUOUT;
        m_reb   <= ~cap_load;
        m_web   <= DmemWEB;
        m_rd    <= IDEXrd;
        m_rw    <= cap_rw;
        wb_data <= m_sel ? dmem_rdata : m_alu;
        wb_rd   <= m_rd;
        wb_we   <= m_rw;
      end else begin
        wb_we   <= 1'b0;
      end
    end
  end

  // Strobes are gated by the state so reset releases them without waiting for a clock.
  assign dmem_reb   = (state == M_IDLE) | m_reb;
  assign dmem_web   = (state == M_IDLE) | m_web;
  assign dmem_addr  = m_alu;
  assign dmem_wdata = m_store;

  assign EXMEMrd       = m_rd;
  assign EXMEMregWrite = m_rw & ~m_sel;
  assign EXMEMvalue    = m_alu;

  assign regfile_indata = wb_data;
  assign WBrd           = wb_rd;
  assign WBregWrite     = wb_we;

endmodule

// File: tb/tb_exmem_wb_block.sv
// Directed table-driven bench for exmem_wb_block plus hand-written wait-state and reset sequences.
module tb_exmem_wb_block;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] ALUResult = 32'd0;
  logic [31:0] StoreData = 32'd0;
  logic        Dmem1ALUOUT = 1'b0;
  logic        DmemREB = 1'b1;
  logic        DmemWEB = 1'b1;
  logic [4:0]  IDEXrd = 5'd0;
  logic        IDEXregWrite = 1'b0;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_reb;
  logic        dmem_web;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ready = 1'b1;
  logic        Stall;
  logic [4:0]  EXMEMrd;
  logic        EXMEMregWrite;
  logic [31:0] EXMEMvalue;
  logic [31:0] regfile_indata;
  logic [4:0]  WBrd;
  logic        WBregWrite;

  exmem_wb_block dut (
    .CLK(CLK), .RST(RST), .ALUResult(ALUResult), .StoreData(StoreData),
    .Dmem1ALUOUT(Dmem1ALUOUT), .DmemREB(DmemREB), .DmemWEB(DmemWEB),
    .IDEXrd(IDEXrd), .IDEXregWrite(IDEXregWrite), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_reb(dmem_reb), .dmem_web(dmem_web),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .Stall(Stall),
    .EXMEMrd(EXMEMrd), .EXMEMregWrite(EXMEMregWrite), .EXMEMvalue(EXMEMvalue),
    .regfile_indata(regfile_indata), .WBrd(WBrd), .WBregWrite(WBregWrite)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        sel;
    logic        reb;
    logic        web;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rdata;
    logic [31:0] e_exval;
    logic        e_exrw;
    logic        e_reb;
    logic        e_web;
    logic [31:0] e_wdata;
    logic        e_wbwe;
    logic [4:0]  e_wbrd;
    logic [31:0] e_wbdata;
  } vec_t;

  vec_t vecs[8];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic sel,
                       input logic reb, input logic web, input logic [4:0] rd, input logic rw);
    ALUResult = alu; StoreData = sd; Dmem1ALUOUT = sel;
    DmemREB = reb; DmemWEB = web; IDEXrd = rd; IDEXregWrite = rw;
  endtask

  task automatic nop();
    drive(32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_indata"}, regfile_indata, 32'd0);
    chk({tag, "_wbwe"}, 32'(WBregWrite), 32'd0);
    chk({tag, "_stall"}, 32'(Stall), 32'd0);
    chk({tag, "_reb"}, 32'(dmem_reb), 32'd1);
    chk({tag, "_web"}, 32'(dmem_web), 32'd1);
    chk({tag, "_exval"}, EXMEMvalue, 32'd0);
  endtask

  initial begin
    //            alu           sd            sel   reb   web   rd     rw    rdata         exval         exrw  reb   web   wdata         wbwe  wbrd   wbdata
    vecs[0] = '{32'h0000_1234, 32'h0,        1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 32'h0,        32'h0000_1234, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 5'd0,  32'h0};
    vecs[1] = '{32'h0000_0040, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,        32'h0000_0040, 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5, 1'b1, 5'd5,  32'h0000_1234};
    vecs[2] = '{32'h0000_0200, 32'h0,        1'b1, 1'b0, 1'b1, 5'd9,  1'b1, 32'h0,        32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 5'd0,  32'h0};
    vecs[3] = '{32'h0000_0204, 32'h0,        1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 32'h1111_2222, 32'h0000_0204, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 5'd9,  32'h1111_2222};
    vecs[4] = '{32'h0000_0080, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 5'd3,  1'b1, 32'h3333_4444, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 5'd10, 32'h3333_4444};
    vecs[5] = '{32'h0000_0077, 32'h0,        1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 32'h5555_6666, 32'h0000_0077, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 5'd3,  32'h0};
    vecs[6] = '{32'h0000_0099, 32'h0,        1'b0, 1'b1, 1'b1, 5'd4,  1'b1, 32'h0,        32'h0000_0099, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 5'd0,  32'h0};
    vecs[7] = '{32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 32'h0,        32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 5'd4,  32'h0000_0099};

    // Reset state at time zero.
    #2;
    chk_reset_outputs("rst0");
    @(negedge CLK);
    RST = 1'b0;

    // Zero-wait pipeline: each vector is captured at the edge, WB shows the previous one.
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      drive(vecs[i].alu, vecs[i].sd, vecs[i].sel, vecs[i].reb, vecs[i].web, vecs[i].rd, vecs[i].rw);
      dmem_rdata = vecs[i].rdata;
      dmem_ready = 1'b1;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_exval", i), EXMEMvalue, vecs[i].e_exval);
      chk($sformatf("v%0d_exrw", i), 32'(EXMEMregWrite), 32'(vecs[i].e_exrw));
      chk($sformatf("v%0d_exrd", i), 32'(EXMEMrd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_reb", i), 32'(dmem_reb), 32'(vecs[i].e_reb));
      chk($sformatf("v%0d_web", i), 32'(dmem_web), 32'(vecs[i].e_web));
      chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].alu);
      chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_stall", i), 32'(Stall), 32'd0);
      chk($sformatf("v%0d_wbwe", i), 32'(WBregWrite), 32'(vecs[i].e_wbwe));
      if (vecs[i].e_wbwe) begin
        chk($sformatf("v%0d_wbrd", i), 32'(WBrd), 32'(vecs[i].e_wbrd));
        chk($sformatf("v%0d_wbdata", i), regfile_indata, vecs[i].e_wbdata);
      end
    end

    // Load with two wait states; EX inputs presented during the stall must be ignored.
    @(negedge CLK);
    drive(32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
    dmem_ready = 1'b0;
    @(posedge CLK);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      drive(32'h0000_0555, 32'h0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1);
      dmem_ready = (c == 2);
      dmem_rdata = (c == 2) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      #1;
      if (Stall) n_stall++;
      chk($sformatf("ld_c%0d_addr", c), dmem_addr, 32'h0000_0100);
      chk($sformatf("ld_c%0d_reb", c), 32'(dmem_reb), 32'd0);
      chk($sformatf("ld_c%0d_exrw", c), 32'(EXMEMregWrite), 32'd0);
      chk($sformatf("ld_c%0d_exval", c), EXMEMvalue, 32'h0000_0100);
      @(posedge CLK);
      #1;
      chk($sformatf("ld_c%0d_wbwe", c), 32'(WBregWrite), (c == 2) ? 32'd1 : 32'd0);
    end
    chk("ld_stall_cycles", 32'(n_stall), 32'd2);
    chk("ld_wbdata", regfile_indata, 32'hDEAD_BEEF);
    chk("ld_wbrd", 32'(WBrd), 32'd7);
    chk("ld_next_exval", EXMEMvalue, 32'h0000_0555);
    chk("ld_next_stall", 32'(Stall), 32'd0);
    @(negedge CLK);
    nop();
    @(posedge CLK);
    #1;
    chk("ld_next_wbdata", regfile_indata, 32'h0000_0555);
    chk("ld_next_wbrd", 32'(WBrd), 32'd8);

    // Reset while the memory is stuck in a wait state.
    @(negedge CLK);
    drive(32'h0000_0300, 32'h0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b1);
    dmem_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nop();
    @(posedge CLK);
    #2;
    chk("wait_stall", 32'(Stall), 32'd1);
    chk("wait_reb", 32'(dmem_reb), 32'd0);
    RST = 1'b1;
    #1;
    chk_reset_outputs("rstw");
    @(negedge CLK);
    RST = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'hFFFF_FFFF;
    drive(32'h0000_4321, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1);
    @(posedge CLK);
    #1;
    chk("post_rst_wbwe0", 32'(WBregWrite), 32'd0);
    chk("post_rst_stall", 32'(Stall), 32'd0);
    @(negedge CLK);
    nop();
    @(posedge CLK);
    #1;
    chk("post_rst_wbwe", 32'(WBregWrite), 32'd1);
    chk("post_rst_wbdata", regfile_indata, 32'h0000_4321);
    chk("post_rst_wbrd", 32'(WBrd), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
